// File: rtl/neopixel_frame_scheduler.sv
// Frame sequencer for the NeopixelController single-pixel shifter.
// Holds a double-buffered GRB frame, streams the front bank one pixel per
// go/ready handshake at a fixed frame rate, then enforces the latch gap.
module neopixel_frame_scheduler #(
  parameter int NUM_PIXELS   = 64,
  parameter int FRAME_CYCLES = 833_333,
  parameter int LATCH_CYCLES = 15_000,
  parameter int AW           = $clog2(NUM_PIXELS)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          swap_req,
  output logic          swap_ack,
  input  logic          pix_ready,
  output logic          pix_go,
  output logic [23:0]   pix_data,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

  localparam int TW = $clog2(FRAME_CYCLES + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam logic [TW-1:0] TICK_AT    = TW'(FRAME_CYCLES - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_PIXELS - 1);
  localparam logic [AW:0]   PIX_LIMIT  = (AW+1)'(NUM_PIXELS);

  typedef enum logic [2:0] {
    IDLE, START, FETCH, SEND, HOLD, DRAIN, LATCH
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          tick;
  logic          tick_pending;
  logic          swap_pending;
  logic          front_sel;
  logic [AW-1:0] idx;
  logic [LW-1:0] latch_cnt;
  logic          wr_ok;
  logic [23:0]   rd_word;
  logic [23:0]   bank0 [NUM_PIXELS];
  logic [23:0]   bank1 [NUM_PIXELS];

  assign tick    = (timer == TICK_AT);
  assign wr_ok   = wr_en && ({1'b0, wr_addr} < PIX_LIMIT);
  assign rd_word = front_sel ? bank1[idx] : bank0[idx];

  // Decodes of registered state: go only while SEND sees ready, so it can
  // never coincide with ready low and never repeats (SEND always exits).
  assign busy     = (state != IDLE);
  assign pix_go   = (state == SEND) && pix_ready;
  assign swap_ack = (state == START) && swap_pending;

  // Free-running frame timer; wraps every FRAME_CYCLES cycles.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Render writes always land in the bank that is not being streamed.
  always_ff @(posedge CLOCK_50) begin
    if (wr_ok) begin
      if (front_sel) begin
        bank0[wr_addr] <= wr_data;
      end else begin
        bank1[wr_addr] <= wr_data;
      end
    end
  end

  // Frame sequencer: start, per-pixel fetch/handshake, drain and latch gap.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      latch_cnt    <= '0;
      front_sel    <= 1'b0;
      tick_pending <= 1'b0;
      swap_pending <= 1'b0;
      overrun      <= 1'b0;
      frame_done   <= 1'b0;
      pix_data     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (swap_req) swap_pending <= 1'b1;
      if (tick) begin
        tick_pending <= 1'b1;
        if (busy) overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          // A tick in this very cycle starts the frame without waiting a cycle.
          if (tick_pending || tick) state <= START;
        end
        START: begin
          idx          <= '0;
          tick_pending <= tick;
          if (swap_pending) begin
            front_sel    <= ~front_sel;
            swap_pending <= swap_req;
          end
          state <= FETCH;
        end
        FETCH: begin
          pix_data <= rd_word;
          state    <= SEND;
        end
        SEND: begin
          if (pix_ready) state <= HOLD;
        end
        HOLD: begin
          // Controller drops ready during this cycle; ready is not sampled here.
          if (idx == LAST_IDX) begin
            state <= DRAIN;
          end else begin
            idx   <= idx + 1'b1;
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (pix_ready) begin
            latch_cnt <= '0;
            state     <= LATCH;
          end
        end
        LATCH: begin
          if (latch_cnt == LATCH_LAST) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_frame_scheduler.sv
// Bench for neopixel_frame_scheduler: random frame contents, a ready model
// of the pixel shifter, and a bank/front model of the double buffer.
module tb_neopixel_frame_scheduler;

  localparam int NP = 12;
  localparam int FC = 500;
  localparam int LC = 40;
  localparam int AW = $clog2(NP);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          swap_req;
  logic          swap_ack;
  logic          pix_ready;
  logic          pix_go;
  logic [23:0]   pix_data;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  neopixel_frame_scheduler #(
    .NUM_PIXELS(NP), .FRAME_CYCLES(FC), .LATCH_CYCLES(LC)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
    .pix_ready(pix_ready), .pix_go(pix_go), .pix_data(pix_data),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel shifter model: ready drops for 'drop' cycles after each go.
  int drop = 30;
  int rcnt = 0;
  bit hold_low = 1'b0;
  always @(posedge clk) begin
    if (pix_go) rcnt <= drop;
    else if (rcnt > 0) rcnt <= rcnt - 1;
  end
  assign pix_ready = (rcnt == 0) && !hold_low;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  logic [23:0] m_bank [2][NP];
  logic [23:0] cap [NP];
  int m_front = 0;
  bit m_swap = 1'b0;
  int last_start = 0;
  int last_done = 0;
  int rel_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = addr[AW-1:0];
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (addr < NP) m_bank[1 - m_front][addr] = d;
  endtask

  task automatic swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    m_swap = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pix_go"}, 32'(pix_go), 32'(0));
    check({tag, " pix_data"}, 32'(pix_data), 32'(0));
    check({tag, " busy"}, 32'(busy), 32'(0));
    check({tag, " frame_done"}, 32'(frame_done), 32'(0));
    check({tag, " swap_ack"}, 32'(swap_ack), 32'(0));
    check({tag, " overrun"}, 32'(overrun), 32'(0));
  endtask

  // Wait for a frame start, then follow the whole frame up to frame_done.
  task automatic run_frame(input string tag, input int ref_cyc, input int exp_delta);
    int t, k, start_cyc, first_go, last_go, proto_err;
    bit prev_go, done;
    t = 0;
    while (!busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " start"}, 32'(busy), 32'(1));
    if (!busy) return;
    start_cyc = cyc;
    if (exp_delta > 0) check({tag, " start time"}, 32'(start_cyc - ref_cyc), 32'(exp_delta));
    check({tag, " swap_ack"}, 32'(swap_ack), 32'(m_swap));
    if (m_swap) m_front = 1 - m_front;
    m_swap = 1'b0;
    k = 0; first_go = -1; last_go = start_cyc; proto_err = 0; prev_go = 1'b0; done = 1'b0;
    for (t = 0; t < 5000 && !done; t++) begin
      @(negedge clk);
      if (pix_go) begin
        if (prev_go || !pix_ready) proto_err++;
        if (first_go < 0) first_go = cyc;
        if (k < NP) begin
          cap[k] = pix_data;
          check($sformatf("%s px%0d", tag, k), 32'(pix_data), 32'(m_bank[m_front][k]));
        end
        k++;
        last_go = cyc;
      end
      prev_go = pix_go;
      if (frame_done) done = 1'b1;
    end
    last_start = start_cyc;
    last_done = cyc;
    check({tag, " frame_done"}, 32'(done), 32'(1));
    check({tag, " go count"}, 32'(k), 32'(NP));
    check({tag, " first go latency"}, 32'(first_go - start_cyc), 32'(2));
    check({tag, " go protocol"}, 32'(proto_err), 32'(0));
    check({tag, " latch gap"}, 32'((cyc - last_go - 1) >= (LC + drop)), 32'(1));
    check({tag, " idle at done"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int t, gos, chg;
    logic [23:0] held;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    rel_cyc = cyc;

    // Fill the back bank, swap it in, stream it.
    for (int i = 0; i < NP; i++) wr(i, 24'($urandom()));
    swap();
    run_frame("f1", rel_cyc, FC);

    // New back bank with pixel 5 green; swap, then repeat without swap.
    for (int i = 0; i < NP; i++) wr(i, 24'($urandom()));
    wr(5, 24'h00FF00);
    swap();
    run_frame("f2", last_start, FC);
    check("f2 sixth go green", 32'(cap[5]), 32'h00FF00);
    run_frame("f3", last_start, FC);
    check("f3 sixth go green", 32'(cap[5]), 32'h00FF00);

    // Out-of-range writes must not disturb any stored pixel.
    wr(0, 24'($urandom()));
    wr(NP, 24'h123456);
    wr(15, 24'hABCDEF);
    swap();
    run_frame("f4", last_start, FC);

    // Reset during the HOLD of pixel 10.
    t = 0; gos = 0;
    while (gos < 11 && t < 2000) begin
      @(negedge clk);
      t++;
      if (pix_go) gos++;
    end
    check("reach px10", 32'(gos), 32'(11));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midframe reset");
    reset = 1'b0;
    rel_cyc = cyc;
    m_front = 0;
    m_swap = 1'b0;
    run_frame("f6", rel_cyc, FC);

    // Slow controller: frames exceed the frame period.
    check("overrun before", 32'(overrun), 32'(0));
    drop = 60;
    run_frame("g1", last_start, FC);
    check("g1 overrun", 32'(overrun), 32'(1));
    run_frame("g2", last_done, 1);
    run_frame("g3", last_done, 1);
    check("g3 overrun sticky", 32'(overrun), 32'(1));

    // Ready held low for 1000 cycles in SEND.
    drop = 30;
    hold_low = 1'b1;
    t = 0;
    while (!busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("hold start", 32'(busy), 32'(1));
    @(negedge clk);
    @(negedge clk);
    held = pix_data;
    check("hold data", 32'(held), 32'(m_bank[m_front][0]));
    gos = 0; chg = 0;
    repeat (1000) begin
      @(negedge clk);
      if (pix_go) gos++;
      if (pix_data !== held) chg++;
    end
    check("hold no go", 32'(gos), 32'(0));
    check("hold data stable", 32'(chg), 32'(0));
    check("hold busy", 32'(busy), 32'(1));
    hold_low = 1'b0;
    #1;
    check("release go", 32'(pix_go), 32'(1));
    @(negedge clk);
    check("release single go", 32'(pix_go), 32'(0));
    gos = 1; t = 0;
    while (!frame_done && t < 5000) begin
      @(negedge clk);
      t++;
      if (pix_go) gos++;
    end
    check("hold frame done", 32'(frame_done), 32'(1));
    check("hold frame go count", 32'(gos), 32'(NP));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
